// File: rtl/lagd_seq_pkg.sv
// Shared types for the macro run sequencer: FSM state encoding and its width.
package lagd_seq_pkg;

    localparam int unsigned SEQ_STATE_W = 3;

    typedef enum logic [SEQ_STATE_W-1:0] {
        IDLE    = 3'd0,
        CFG_EM  = 3'd1,
        CFG_FM  = 3'd2,
        CFG_AW  = 3'd3,
        LOAD    = 3'd4,
        RUN     = 3'd5,
        DRAIN   = 3'd6,
        READOUT = 3'd7
    } seq_state_e;

endpackage

// File: rtl/macro_sequencer_if.sv
// Host/macro handshake bundle of the run sequencer; slave = sequencer side, master = host/macro side.
interface macro_sequencer_if #(
    parameter int unsigned ITER_BIT     = 16,
    parameter int unsigned LOAD_TMO_BIT = 20
);
    logic                    start_i;
    logic                    abort_i;
    logic                    skip_spin_init_i;
    logic [ITER_BIT-1:0]     num_iter_i;
    logic [LOAD_TMO_BIT-1:0] wdog_limit_i;
    logic                    load_idle_i;
    logic                    cmpt_idle_i;
    logic                    iter_done_i;
    logic                    readout_ack_i;
    logic                    macro_en_o;
    logic                    cfg_valid_em_o;
    logic                    cfg_valid_fm_o;
    logic                    cfg_valid_aw_o;
    logic                    cfg_skip_o;
    logic                    dt_cfg_en_o;
    logic                    cmpt_en_o;
    logic                    flush_o;
    logic                    host_readout_o;
    logic                    busy_o;
    logic                    done_o;
    logic                    err_o;
    logic [ITER_BIT-1:0]     iter_cnt_o;

    modport slave (
        input  start_i, abort_i, skip_spin_init_i, num_iter_i, wdog_limit_i,
               load_idle_i, cmpt_idle_i, iter_done_i, readout_ack_i,
        output macro_en_o, cfg_valid_em_o, cfg_valid_fm_o, cfg_valid_aw_o, cfg_skip_o,
               dt_cfg_en_o, cmpt_en_o, flush_o, host_readout_o, busy_o, done_o, err_o,
               iter_cnt_o
    );

    modport master (
        output start_i, abort_i, skip_spin_init_i, num_iter_i, wdog_limit_i,
               load_idle_i, cmpt_idle_i, iter_done_i, readout_ack_i,
        input  macro_en_o, cfg_valid_em_o, cfg_valid_fm_o, cfg_valid_aw_o, cfg_skip_o,
               dt_cfg_en_o, cmpt_en_o, flush_o, host_readout_o, busy_o, done_o, err_o,
               iter_cnt_o
    );

endinterface

// File: rtl/seq_wdog.sv
// Loadable cycle counter with limit compare; expire_o fires in the cycle the count reaches the limit.
module seq_wdog #(
    parameter int unsigned CNT_BIT = 20
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clr_i,
    input  logic               en_i,
    input  logic [CNT_BIT-1:0] limit_i,
    output logic               expire_o
);
    logic [CNT_BIT-1:0] cnt_q, cnt_d;
    logic [CNT_BIT:0]   cnt_inc_s;

    assign cnt_inc_s = {1'b0, cnt_q} + {{CNT_BIT{1'b0}}, 1'b1};
    assign expire_o  = en_i && (cnt_inc_s >= {1'b0, limit_i});

    // Next count: clear on phase change, saturating increment while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !cnt_inc_s[CNT_BIT]) begin
            cnt_d = cnt_inc_s[CNT_BIT-1:0];
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/macro_sequencer.sv
// Run controller for one annealing job on the compute macro (config, load, compute, drain, readout).
// Define MACRO_SEQ_WDOG_EN to add a watchdog over the LOAD and DRAIN waits.
module macro_sequencer
    import lagd_seq_pkg::*;
#(
    parameter int unsigned ITER_BIT     = 16,
    parameter int unsigned LOAD_TMO_BIT = 20
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    macro_sequencer_if.slave  bus
);
    seq_state_e          state_q, state_d, dec_s;
    logic [ITER_BIT-1:0] num_iter_q;
    logic [ITER_BIT-1:0] iter_cnt_q, iter_cnt_d;
    logic                skip_cfg_q, load_seen_q;
    logic                err_q, err_d;
    logic                flush_d, done_d;
    logic                start_s, abort_s, wdog_expire_s;
    logic                macro_en_q, busy_q, cfg_em_q, cfg_fm_q, cfg_aw_q, cfg_skip_q;
    logic                dt_cfg_en_q, cmpt_en_q, host_readout_q, flush_q, done_q;

    assign start_s = (state_q == IDLE) && bus.start_i;
    assign abort_s = (state_q != IDLE) && (bus.abort_i || wdog_expire_s);
    // An aborting cycle decodes as IDLE so no phase output survives into the flush cycle.
    assign dec_s   = abort_s ? IDLE : state_q;

`ifdef MACRO_SEQ_WDOG_EN
    logic [LOAD_TMO_BIT-1:0] wdog_limit_q;
    logic                    wdog_en_s;

    assign wdog_en_s = (state_q == LOAD) || (state_q == DRAIN);

    // Watchdog limit captured with the job.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wdog_limit_q <= '0;
        end else if (start_s) begin
            wdog_limit_q <= bus.wdog_limit_i;
        end else begin
            wdog_limit_q <= wdog_limit_q;
        end
    end

    seq_wdog #(.CNT_BIT(LOAD_TMO_BIT)) u_wdog (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (state_d != state_q),
        .en_i     (wdog_en_s),
        .limit_i  (wdog_limit_q),
        .expire_o (wdog_expire_s)
    );
`else
    logic [LOAD_TMO_BIT-1:0] unused_wdog_s;

    assign unused_wdog_s = bus.wdog_limit_i;
    assign wdog_expire_s = 1'b0;
`endif

    // Next-state logic; abort overrides every phase.
    always_comb begin
        state_d = state_q;
        if (abort_s) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (bus.start_i) state_d = CFG_EM; else state_d = IDLE;
                CFG_EM:  state_d = CFG_FM;
                CFG_FM:  state_d = CFG_AW;
                CFG_AW:  state_d = LOAD;
                LOAD: begin
                    if (load_seen_q && bus.load_idle_i) begin
                        if (num_iter_q == '0) state_d = DRAIN; else state_d = RUN;
                    end else begin
                        state_d = LOAD;
                    end
                end
                RUN:     if (iter_cnt_q >= num_iter_q) state_d = DRAIN; else state_d = RUN;
                DRAIN:   if (bus.cmpt_idle_i) state_d = READOUT; else state_d = DRAIN;
                READOUT: if (bus.readout_ack_i) state_d = IDLE; else state_d = READOUT;
                default: state_d = IDLE;
            endcase
        end
    end

    // Iteration count, sticky error and the pulse outputs' next values.
    always_comb begin
        iter_cnt_d = iter_cnt_q;
        err_d      = err_q;
        flush_d    = 1'b0;
        done_d     = 1'b0;
        if (start_s) begin
            iter_cnt_d = '0;
            err_d      = 1'b0;
        end else if (abort_s) begin
            err_d   = 1'b1;
            flush_d = 1'b1;
        end else begin
            if ((state_q == RUN) && bus.iter_done_i && (iter_cnt_q < num_iter_q)) begin
                iter_cnt_d = iter_cnt_q + {{(ITER_BIT-1){1'b0}}, 1'b1};
            end else begin
                iter_cnt_d = iter_cnt_q;
            end
            flush_d = (state_q == DRAIN) && bus.cmpt_idle_i;
            done_d  = (state_q == READOUT) && bus.readout_ack_i;
        end
    end

    // FSM and job-context registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            num_iter_q  <= '0;
            skip_cfg_q  <= 1'b0;
            load_seen_q <= 1'b0;
            iter_cnt_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_seen_q <= (dec_s == LOAD);
            iter_cnt_q  <= iter_cnt_d;
            err_q       <= err_d;
            if (start_s) begin
                num_iter_q <= bus.num_iter_i;
                skip_cfg_q <= bus.skip_spin_init_i;
            end else begin
                num_iter_q <= num_iter_q;
                skip_cfg_q <= skip_cfg_q;
            end
        end
    end

    // Registered control outputs, one cycle behind the state they decode.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            macro_en_q     <= 1'b0;
            busy_q         <= 1'b0;
            cfg_em_q       <= 1'b0;
            cfg_fm_q       <= 1'b0;
            cfg_aw_q       <= 1'b0;
            cfg_skip_q     <= 1'b0;
            dt_cfg_en_q    <= 1'b0;
            cmpt_en_q      <= 1'b0;
            host_readout_q <= 1'b0;
            flush_q        <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            macro_en_q     <= (state_q != IDLE);
            busy_q         <= (state_q != IDLE);
            cfg_em_q       <= (dec_s == CFG_EM);
            cfg_fm_q       <= (dec_s == CFG_FM);
            cfg_aw_q       <= (dec_s == CFG_AW);
            cfg_skip_q     <= (state_q != IDLE) && skip_cfg_q;
            dt_cfg_en_q    <= (dec_s == LOAD);
            cmpt_en_q      <= (dec_s == RUN);
            host_readout_q <= (dec_s == READOUT);
            flush_q        <= flush_d;
            done_q         <= done_d;
        end
    end

    assign bus.macro_en_o     = macro_en_q;
    assign bus.busy_o         = busy_q;
    assign bus.cfg_valid_em_o = cfg_em_q;
    assign bus.cfg_valid_fm_o = cfg_fm_q;
    assign bus.cfg_valid_aw_o = cfg_aw_q;
    assign bus.cfg_skip_o     = cfg_skip_q;
    assign bus.dt_cfg_en_o    = dt_cfg_en_q;
    assign bus.cmpt_en_o      = cmpt_en_q;
    assign bus.host_readout_o = host_readout_q;
    assign bus.flush_o        = flush_q;
    assign bus.done_o         = done_q;
    assign bus.err_o          = err_q;
    assign bus.iter_cnt_o     = iter_cnt_q;

endmodule

// File: tb/tb_macro_sequencer.sv
// Directed self-checking bench for macro_sequencer; cycle numbers count posedges since the job's start edge.
module tb_macro_sequencer;

    logic clk;
    logic rst_n;

    macro_sequencer_if bus ();

    macro_sequencer u_dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc;
    int em_n, em_at, fm_n, fm_at, aw_n, aw_at, dt_n, cmpt_n;
    int flush_n, flush_at, done_n, done_at, busy_n, ro_n, skip_n;
    logic [15:0] cnt_at_load;
    logic [11:0] ctl_s;

    assign ctl_s = {bus.macro_en_o, bus.cfg_valid_em_o, bus.cfg_valid_fm_o, bus.cfg_valid_aw_o,
                    bus.cfg_skip_o, bus.dt_cfg_en_o, bus.cmpt_en_o, bus.flush_o,
                    bus.host_readout_o, bus.busy_o, bus.done_o, bus.err_o};

    task automatic clr_tally();
        cyc = 0; em_n = 0; em_at = 0; fm_n = 0; fm_at = 0; aw_n = 0; aw_at = 0;
        dt_n = 0; cmpt_n = 0; flush_n = 0; flush_at = 0; done_n = 0; done_at = 0;
        busy_n = 0; ro_n = 0; skip_n = 0;
    endtask

    // One clock, then sample #1 after the edge and tally every output pulse.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.cfg_valid_em_o) begin em_n++; em_at = cyc; end
        if (bus.cfg_valid_fm_o) begin fm_n++; fm_at = cyc; end
        if (bus.cfg_valid_aw_o) begin aw_n++; aw_at = cyc; end
        if (bus.dt_cfg_en_o)    dt_n++;
        if (bus.cmpt_en_o)      cmpt_n++;
        if (bus.flush_o)        begin flush_n++; flush_at = cyc; end
        if (bus.done_o)         begin done_n++; done_at = cyc; end
        if (bus.busy_o)         busy_n++;
        if (bus.host_readout_o) ro_n++;
        if (bus.cfg_skip_o)     skip_n++;
    endtask

    // Full job: load_idle from cycle 9, n_pulses iter_done pulses two cycles apart, cmpt_idle after drain_wait.
    task automatic run_job(input logic [15:0] n_iter, input int n_pulses, input int drain_wait,
                           input logic skip, input logic noise);
        int guard;
        clr_tally();
        bus.wdog_limit_i     = 20'hFFFFF;
        bus.cmpt_idle_i      = 1'b0;
        bus.num_iter_i       = n_iter;
        bus.skip_spin_init_i = skip;
        bus.start_i          = 1'b1;
        step();
        bus.start_i          = 1'b0;
        bus.skip_spin_init_i = 1'b0;
        repeat (7) begin
            bus.start_i     = noise;
            bus.iter_done_i = noise;
            step();
        end
        bus.start_i     = 1'b0;
        bus.iter_done_i = 1'b0;
        cnt_at_load     = bus.iter_cnt_o;
        bus.load_idle_i = 1'b1;
        step();
        bus.load_idle_i = 1'b0;
        for (int k = 0; k < n_pulses; k++) begin
            bus.iter_done_i = 1'b1;
            step();
            bus.iter_done_i = 1'b0;
            step();
        end
        repeat (drain_wait) step();
        bus.cmpt_idle_i = 1'b1;
        guard = 0;
        while (!bus.host_readout_o && guard < 50) begin
            step();
            guard++;
        end
        checks++;
        if (guard >= 50) begin errors++; $display("FAIL readout_wait: host_readout_o not seen within %0d cycles", guard); end
        repeat (2) step();
        bus.readout_ack_i = 1'b1;
        step();
        bus.readout_ack_i = 1'b0;
        step();
        bus.cmpt_idle_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ctl_s !== 12'h000) begin errors++; $display("FAIL reset_outputs: got %h expected 000", ctl_s); end
        rst_n = 1'b1;
        clr_tally();
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (ctl_s !== 12'h000 || bus.iter_cnt_o !== 16'd0) begin
                errors++;
                $display("FAIL idle_outputs: cycle %0d got ctl=%h cnt=%0d expected ctl=000 cnt=0", i, ctl_s, bus.iter_cnt_o);
            end
        end
    endtask

    task automatic test_nominal();
        run_job(16'd3, 3, 2, 1'b1, 1'b0);
        checks++; if (em_n !== 1 || em_at !== 2) begin errors++; $display("FAIL nom_cfg_em: got n=%0d at=%0d expected n=1 at=2", em_n, em_at); end
        checks++; if (fm_n !== 1 || fm_at !== 3) begin errors++; $display("FAIL nom_cfg_fm: got n=%0d at=%0d expected n=1 at=3", fm_n, fm_at); end
        checks++; if (aw_n !== 1 || aw_at !== 4) begin errors++; $display("FAIL nom_cfg_aw: got n=%0d at=%0d expected n=1 at=4", aw_n, aw_at); end
        checks++; if (dt_n !== 5) begin errors++; $display("FAIL nom_dt_cfg: got %0d cycles expected 5", dt_n); end
        checks++; if (cmpt_n !== 6) begin errors++; $display("FAIL nom_cmpt_en: got %0d cycles expected 6", cmpt_n); end
        checks++; if (bus.iter_cnt_o !== 16'd3) begin errors++; $display("FAIL nom_iter_cnt: got %0d expected 3", bus.iter_cnt_o); end
        checks++; if (flush_n !== 1 || flush_at !== 18) begin errors++; $display("FAIL nom_flush: got n=%0d at=%0d expected n=1 at=18", flush_n, flush_at); end
        checks++; if (ro_n !== 4) begin errors++; $display("FAIL nom_readout: got %0d cycles expected 4", ro_n); end
        checks++; if (done_n !== 1 || done_at !== 22) begin errors++; $display("FAIL nom_done: got n=%0d at=%0d expected n=1 at=22", done_n, done_at); end
        checks++; if (busy_n !== 21 || skip_n !== 21) begin errors++; $display("FAIL nom_busy_skip: got busy=%0d skip=%0d expected 21 21", busy_n, skip_n); end
        checks++; if (bus.busy_o !== 1'b0 || bus.err_o !== 1'b0) begin errors++; $display("FAIL nom_end: got busy=%b err=%b expected 0 0", bus.busy_o, bus.err_o); end
    endtask

    task automatic test_zero_iter();
        run_job(16'd0, 0, 0, 1'b0, 1'b0);
        checks++; if (cmpt_n !== 0) begin errors++; $display("FAIL zero_cmpt_en: got %0d cycles expected 0", cmpt_n); end
        checks++; if (dt_n !== 5) begin errors++; $display("FAIL zero_dt_cfg: got %0d cycles expected 5", dt_n); end
        checks++; if (flush_n !== 1 || flush_at !== 10) begin errors++; $display("FAIL zero_flush: got n=%0d at=%0d expected n=1 at=10", flush_n, flush_at); end
        checks++; if (done_n !== 1 || done_at !== 14) begin errors++; $display("FAIL zero_done: got n=%0d at=%0d expected n=1 at=14", done_n, done_at); end
        checks++; if (busy_n !== 13 || skip_n !== 0) begin errors++; $display("FAIL zero_busy_skip: got busy=%0d skip=%0d expected 13 0", busy_n, skip_n); end
        checks++; if (bus.iter_cnt_o !== 16'd0) begin errors++; $display("FAIL zero_iter_cnt: got %0d expected 0", bus.iter_cnt_o); end
    endtask

    task automatic test_abort();
        clr_tally();
        bus.wdog_limit_i = 20'hFFFFF;
        bus.num_iter_i   = 16'd5;
        bus.start_i      = 1'b1;
        step();
        bus.start_i      = 1'b0;
        repeat (7) step();
        bus.load_idle_i  = 1'b1;
        step();
        bus.load_idle_i  = 1'b0;
        repeat (2) begin
            bus.iter_done_i = 1'b1;
            step();
            bus.iter_done_i = 1'b0;
            step();
        end
        checks++; if (bus.iter_cnt_o !== 16'd2 || bus.cmpt_en_o !== 1'b1) begin errors++; $display("FAIL abort_pre: got cnt=%0d cmpt=%b expected 2 1", bus.iter_cnt_o, bus.cmpt_en_o); end
        bus.abort_i = 1'b1;
        step();
        bus.abort_i = 1'b0;
        checks++; if (bus.flush_o !== 1'b1 || bus.err_o !== 1'b1 || bus.cmpt_en_o !== 1'b0) begin errors++; $display("FAIL abort_flush: got flush=%b err=%b cmpt=%b expected 1 1 0", bus.flush_o, bus.err_o, bus.cmpt_en_o); end
        step();
        checks++; if (bus.busy_o !== 1'b0 || bus.flush_o !== 1'b0 || bus.err_o !== 1'b1) begin errors++; $display("FAIL abort_idle: got busy=%b flush=%b err=%b expected 0 0 1", bus.busy_o, bus.flush_o, bus.err_o); end
        repeat (5) step();
        checks++; if (done_n !== 0 || flush_n !== 1 || bus.iter_cnt_o !== 16'd2) begin errors++; $display("FAIL abort_after: got done=%0d flush=%0d cnt=%0d expected 0 1 2", done_n, flush_n, bus.iter_cnt_o); end
        bus.start_i = 1'b1;
        bus.abort_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        checks++; if (bus.err_o !== 1'b0 || bus.iter_cnt_o !== 16'd0) begin errors++; $display("FAIL restart_clear: got err=%b cnt=%0d expected 0 0", bus.err_o, bus.iter_cnt_o); end
        step();
        checks++; if (bus.busy_o !== 1'b1 || bus.cfg_valid_em_o !== 1'b1) begin errors++; $display("FAIL start_wins: got busy=%b em=%b expected 1 1", bus.busy_o, bus.cfg_valid_em_o); end
        bus.abort_i = 1'b1;
        step();
        bus.abort_i = 1'b0;
        step();
        checks++; if (bus.busy_o !== 1'b0 || bus.err_o !== 1'b1) begin errors++; $display("FAIL cfg_abort: got busy=%b err=%b expected 0 1", bus.busy_o, bus.err_o); end
    endtask

    task automatic test_busy_ignore();
        run_job(16'd2, 2, 0, 1'b0, 1'b1);
        checks++; if (cnt_at_load !== 16'd0) begin errors++; $display("FAIL load_iter_ignored: got %0d expected 0", cnt_at_load); end
        checks++; if (em_n !== 1 || em_at !== 2) begin errors++; $display("FAIL busy_start_ignored: got em n=%0d at=%0d expected 1 2", em_n, em_at); end
        checks++; if (bus.iter_cnt_o !== 16'd2 || cmpt_n !== 4) begin errors++; $display("FAIL busy_run: got cnt=%0d cmpt=%0d expected 2 4", bus.iter_cnt_o, cmpt_n); end
        checks++; if (done_n !== 1 || done_at !== 18 || bus.err_o !== 1'b0) begin errors++; $display("FAIL busy_done: got n=%0d at=%0d err=%b expected 1 18 0", done_n, done_at, bus.err_o); end
    endtask

    task automatic test_reset_mid_job();
        clr_tally();
        bus.num_iter_i = 16'd4;
        bus.start_i    = 1'b1;
        step();
        bus.start_i    = 1'b0;
        repeat (4) step();
        checks++; if (bus.macro_en_o !== 1'b1 || bus.dt_cfg_en_o !== 1'b1) begin errors++; $display("FAIL mid_pre: got en=%b dt=%b expected 1 1", bus.macro_en_o, bus.dt_cfg_en_o); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (ctl_s !== 12'h000 || bus.iter_cnt_o !== 16'd0) begin errors++; $display("FAIL mid_reset: got ctl=%h cnt=%0d expected 000 0", ctl_s, bus.iter_cnt_o); end
        step();
        step();
        rst_n = 1'b1;
        step();
        checks++; if (ctl_s !== 12'h000 || flush_n !== 0) begin errors++; $display("FAIL mid_release: got ctl=%h flushes=%0d expected 000 0", ctl_s, flush_n); end
    endtask

`ifdef MACRO_SEQ_WDOG_EN
    task automatic test_wdog();
        clr_tally();
        bus.wdog_limit_i = 20'd10;
        bus.num_iter_i   = 16'd1;
        bus.start_i      = 1'b1;
        step();
        bus.start_i      = 1'b0;
        repeat (12) step();
        checks++; if (bus.err_o !== 1'b0 || bus.dt_cfg_en_o !== 1'b1) begin errors++; $display("FAIL wdog_early: got err=%b dt=%b expected 0 1", bus.err_o, bus.dt_cfg_en_o); end
        step();
        checks++; if (bus.err_o !== 1'b1 || bus.flush_o !== 1'b1) begin errors++; $display("FAIL wdog_fire: got err=%b flush=%b expected 1 1", bus.err_o, bus.flush_o); end
        step();
        checks++; if (bus.busy_o !== 1'b0 || dt_n !== 9 || done_n !== 0) begin errors++; $display("FAIL wdog_idle: got busy=%b dt=%0d done=%0d expected 0 9 0", bus.busy_o, dt_n, done_n); end
        bus.wdog_limit_i = 20'hFFFFF;
    endtask
`endif

    initial begin
        rst_n                = 1'b0;
        bus.start_i          = 1'b0;
        bus.abort_i          = 1'b0;
        bus.skip_spin_init_i = 1'b0;
        bus.num_iter_i       = 16'd0;
        bus.wdog_limit_i     = 20'hFFFFF;
        bus.load_idle_i      = 1'b0;
        bus.cmpt_idle_i      = 1'b0;
        bus.iter_done_i      = 1'b0;
        bus.readout_ack_i    = 1'b0;
        test_reset();
        test_nominal();
        test_zero_iter();
        test_abort();
        test_busy_ignore();
        test_reset_mid_job();
`ifdef MACRO_SEQ_WDOG_EN
        test_wdog();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench still running after 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
